// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. It holds the PC, a direct-mapped one-word-per-line
//   instruction cache with a miss-fill FSM, and the IF/ID pipeline register.
//   It sits directly upstream of stall_control: it reports
//   instruction_not_ready and obeys the stall/bubble decisions sent back.
//
// Ports
//   clk                    clock; all state changes on the rising edge
//   reset_n                asynchronous active-low reset
//   stall_in               hold PC and IF/ID
//   bubble_in              force IF/ID to a bubble on the next edge
//   redirect_valid         PC redirect (branch, iret or exception)
//   redirect_pc            redirect target; bits [1:0] are ignored
//   imem_ack               single-cycle fill-data strobe
//   imem_rdata             fill data, sampled while imem_ack=1
//   imem_req               fill request level, held until ack
//   imem_addr              word-aligned fill address
//   instruction_not_ready  no instruction available for the current PC
//   if_id_valid            IF/ID holds a real instruction
//   if_id_pc               PC of the IF/ID instruction
//   if_id_instr            IF/ID instruction, 0 (NOP) for a bubble
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    PC_WIDTH    = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    LINES       = 16,
  parameter logic [PC_WIDTH-1:0]   BOOT_PC     = PC_WIDTH'(32'h0000_1000)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall_in,
  input  logic                   bubble_in,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   instruction_not_ready,
  output logic                   if_id_valid,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [PC_WIDTH-1:0]      r_pc;
  logic [PC_WIDTH-1:0]      r_miss_addr;
  logic [LINES-1:0]         r_valid;
  logic [TAG_W-1:0]         r_tag_ram  [LINES];
  logic [INSTR_WIDTH-1:0]   r_data_ram [LINES];
  logic                     r_if_id_valid;
  logic [PC_WIDTH-1:0]      r_if_id_pc;
  logic [INSTR_WIDTH-1:0]   r_if_id_instr;

  logic [IDX_W-1:0]         w_index;
  logic [TAG_W-1:0]         w_tag;
  logic [IDX_W-1:0]         w_fill_index;
  logic [TAG_W-1:0]         w_fill_tag;
  logic                     w_hit;
  logic                     w_not_ready;
  logic                     w_fill_done;
  logic [PC_WIDTH-1:0]      w_redirect_aligned;

  // Combinational cache lookup of the current PC.
  assign w_index      = r_pc[IDX_W+1:2];
  assign w_tag        = r_pc[PC_WIDTH-1:IDX_W+2];
  assign w_fill_index = r_miss_addr[IDX_W+1:2];
  assign w_fill_tag   = r_miss_addr[PC_WIDTH-1:IDX_W+2];
  assign w_hit        = r_valid[w_index] && (r_tag_ram[w_index] == w_tag);

  assign w_not_ready  = (r_state == S_FILL) || !w_hit;
  assign w_fill_done  = (r_state == S_FILL) && imem_ack;

  // Instructions are word aligned, so the low two target bits are dropped.
  assign w_redirect_aligned = redirect_pc & ~PC_WIDTH'(3);

  // Miss-fill FSM, next-state half. A redirect seen in IDLE suppresses the
  // fill because the missing PC is about to be replaced anyway; once in FILL
  // the fill always runs to completion since its data is valid for miss_addr.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (!w_hit && !redirect_valid) w_state_next = S_FILL;
      S_FILL: if (imem_ack)                  w_state_next = S_IDLE;
      default:                               w_state_next = S_IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of process order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pc        <= BOOT_PC;
      r_miss_addr <= '0;
      r_valid     <= '0;
    end else begin
      r_state <= w_state_next;

      if (r_state == S_IDLE && w_state_next == S_FILL) r_miss_addr <= r_pc;

      if (w_fill_done) r_valid[w_fill_index] <= 1'b1;

      if (redirect_valid)   r_pc <= w_redirect_aligned;
      else if (stall_in)    r_pc <= r_pc;
      else if (w_not_ready) r_pc <= r_pc;
      else                  r_pc <= r_pc + PC_WIDTH'(4);
    end
  end

  // NOTE: tag and data arrays carry no reset; the reset-cleared valid bits
  // already make every line a miss, and leaving them unreset lets them map
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag_ram[w_fill_index]  <= w_fill_tag;
      r_data_ram[w_fill_index] <= imem_rdata;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= '0;
    end else if (redirect_valid || bubble_in) begin
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= '0;
    end else if (stall_in) begin
      r_if_id_valid <= r_if_id_valid;
      r_if_id_pc    <= r_if_id_pc;
      r_if_id_instr <= r_if_id_instr;
    end else if (w_not_ready) begin
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= '0;
    end else begin
      r_if_id_valid <= 1'b1;
      r_if_id_pc    <= r_pc;
      r_if_id_instr <= r_data_ram[w_index];
    end
  end

  // imem_addr simply mirrors miss_addr; it is only meaningful while imem_req=1.
  assign imem_req              = (r_state == S_FILL);
  assign imem_addr             = r_miss_addr;
  assign instruction_not_ready = w_not_ready;
  assign if_id_valid           = r_if_id_valid;
  assign if_id_pc              = r_if_id_pc;
  assign if_id_instr           = r_if_id_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. Inputs are driven and outputs sampled on the
//   falling clock edge; the DUT updates on the rising edge. Scenarios run as
//   one continuous timeline, each task picking up where the previous one left
//   the DUT.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_in;
  logic        bubble_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instruction_not_ready;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] D1000 = 32'h2002_0001;
  localparam logic [31:0] D1004 = 32'hAAAA_0004;
  localparam logic [31:0] D3000 = 32'h3333_0000;
  localparam logic [31:0] D1008 = 32'h0800_1008;
  localparam logic [31:0] D100C = 32'h0C00_100C;
  localparam logic [31:0] D1040 = 32'h4040_0000;

  fetch_unit dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .stall_in              (stall_in),
    .bubble_in             (bubble_in),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .imem_ack              (imem_ack),
    .imem_rdata            (imem_rdata),
    .imem_req              (imem_req),
    .imem_addr             (imem_addr),
    .instruction_not_ready (instruction_not_ready),
    .if_id_valid           (if_id_valid),
    .if_id_pc              (if_id_pc),
    .if_id_instr           (if_id_instr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one ack cycle with the given fill data, then drop ack.
  task automatic ack_fill(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall_in = 1'b0; bubble_in = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) tick();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_id_valid); end
    n_checks++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", if_id_pc); end
    n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", if_id_instr); end
    n_checks++; if (instruction_not_ready !== 1'b1) begin n_fail++; $display("FAIL rst_nready: got %b want 1", instruction_not_ready); end
    // Cycle 0: reset released, still IDLE with a miss on BOOT_PC.
    reset_n = 1'b1;
    #1;
    n_checks++; if (instruction_not_ready !== 1'b1) begin n_fail++; $display("FAIL c0_nready: got %b want 1", instruction_not_ready); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL c0_req: got %b want 0", imem_req); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL c0_valid: got %b want 0", if_id_valid); end
  endtask

  task automatic test_miss_fill();
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fill_req_c%0d: got %b want 1", c, imem_req); end
      n_checks++; if (imem_addr !== 32'h1000) begin n_fail++; $display("FAIL fill_addr_c%0d: got %h want 00001000", c, imem_addr); end
    end
    ack_fill(D1000);
    n_checks++; if (instruction_not_ready !== 1'b0) begin n_fail++; $display("FAIL hit_nready: got %b want 0", instruction_not_ready); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hit_req: got %b want 0", imem_req); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL hit_valid_early: got %b want 0", if_id_valid); end
    tick();
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %b want 1", if_id_valid); end
    n_checks++; if (if_id_pc !== 32'h1000) begin n_fail++; $display("FAIL load_pc: got %h want 00001000", if_id_pc); end
    n_checks++; if (if_id_instr !== D1000) begin n_fail++; $display("FAIL load_instr: got %h want %h", if_id_instr, D1000); end
    // PC advanced to 0x1004, which misses.
    n_checks++; if (instruction_not_ready !== 1'b1) begin n_fail++; $display("FAIL pc1004_nready: got %b want 1", instruction_not_ready); end
  endtask

  task automatic test_redirect_hit();
    // Redirect while IDLE on a miss: no fill must start.
    redirect_valid = 1'b1; redirect_pc = 32'h1000;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b want 0", imem_req); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b want 0", if_id_valid); end
    n_checks++; if (instruction_not_ready !== 1'b0) begin n_fail++; $display("FAIL redir_nready: got %b want 0", instruction_not_ready); end
    tick();
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL redir_hit_valid: got %b want 1", if_id_valid); end
    n_checks++; if (if_id_pc !== 32'h1000) begin n_fail++; $display("FAIL redir_hit_pc: got %h want 00001000", if_id_pc); end
    n_checks++; if (if_id_instr !== D1000) begin n_fail++; $display("FAIL redir_hit_instr: got %h want %h", if_id_instr, D1000); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_hit_req: got %b want 0", imem_req); end
  endtask

  task automatic test_fill_redirect();
    tick();
    n_checks++; if (imem_addr !== 32'h1004) begin n_fail++; $display("FAIL f4_addr: got %h want 00001004", imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h3002;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL f4_req_kept: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h1004) begin n_fail++; $display("FAIL f4_addr_kept: got %h want 00001004", imem_addr); end
    ack_fill(D1004);
    n_checks++; if (instruction_not_ready !== 1'b1) begin n_fail++; $display("FAIL f3_nready: got %b want 1", instruction_not_ready); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL f3_idle_req: got %b want 0", imem_req); end
    tick();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL f3_req: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL f3_addr: got %h want 00003000", imem_addr); end
    ack_fill(D3000);
    n_checks++; if (instruction_not_ready !== 1'b0) begin n_fail++; $display("FAIL f3_hit: got %b want 1'b0", instruction_not_ready); end
    // Line 1 must now hold 0x1004's data from the uncancelled fill.
    redirect_valid = 1'b1; redirect_pc = 32'h1004;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (instruction_not_ready !== 1'b0) begin n_fail++; $display("FAIL l1_hit: got %b want 0", instruction_not_ready); end
    tick();
    n_checks++; if (if_id_pc !== 32'h1004) begin n_fail++; $display("FAIL l1_pc: got %h want 00001004", if_id_pc); end
    n_checks++; if (if_id_instr !== D1004) begin n_fail++; $display("FAIL l1_instr: got %h want %h", if_id_instr, D1004); end
  endtask

  task automatic test_stall_bubble();
    // Fill 0x1008 and 0x100C so a three-word hit stream exists.
    tick();
    n_checks++; if (imem_addr !== 32'h1008) begin n_fail++; $display("FAIL sb_addr8: got %h want 00001008", imem_addr); end
    ack_fill(D1008);
    tick();
    tick();
    n_checks++; if (imem_addr !== 32'h100C) begin n_fail++; $display("FAIL sb_addrC: got %h want 0000100c", imem_addr); end
    ack_fill(D100C);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h1004;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++; if (if_id_pc !== 32'h1004) begin n_fail++; $display("FAIL sb_pre_pc: got %h want 00001004", if_id_pc); end
    stall_in = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (if_id_pc !== 32'h1004) begin n_fail++; $display("FAIL stall_pc_%0d: got %h want 00001004", c, if_id_pc); end
      n_checks++; if (if_id_instr !== D1004) begin n_fail++; $display("FAIL stall_instr_%0d: got %h want %h", c, if_id_instr, D1004); end
      n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_%0d: got %b want 1", c, if_id_valid); end
    end
    stall_in = 1'b0; bubble_in = 1'b1;
    tick();
    bubble_in = 1'b0;
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL bub_valid: got %b want 0", if_id_valid); end
    n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL bub_instr: got %h want 0", if_id_instr); end
    tick();
    // PC held at 0x1008 through the stall, then stepped once during the bubble.
    n_checks++; if (if_id_pc !== 32'h100C) begin n_fail++; $display("FAIL bub_next_pc: got %h want 0000100c", if_id_pc); end
    n_checks++; if (if_id_instr !== D100C) begin n_fail++; $display("FAIL bub_next_instr: got %h want %h", if_id_instr, D100C); end
  endtask

  task automatic test_evict_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h1000;
    tick();
    redirect_valid = 1'b0;
    // Line 0 currently holds 0x3000, so 0x1000 misses.
    n_checks++; if (instruction_not_ready !== 1'b1) begin n_fail++; $display("FAIL ev_miss1000: got %b want 1", instruction_not_ready); end
    tick();
    n_checks++; if (imem_addr !== 32'h1000) begin n_fail++; $display("FAIL ev_addr1000: got %h want 00001000", imem_addr); end
    // Ack and redirect in the same FILL cycle.
    redirect_valid = 1'b1; redirect_pc = 32'h1040;
    ack_fill(D1000);
    redirect_valid = 1'b0;
    n_checks++; if (instruction_not_ready !== 1'b1) begin n_fail++; $display("FAIL ev_miss1040: got %b want 1", instruction_not_ready); end
    tick();
    n_checks++; if (imem_addr !== 32'h1040) begin n_fail++; $display("FAIL ev_addr1040: got %h want 00001040", imem_addr); end
    ack_fill(D1040);
    tick();
    n_checks++; if (if_id_pc !== 32'h1040) begin n_fail++; $display("FAIL ev_pc1040: got %h want 00001040", if_id_pc); end
    n_checks++; if (if_id_instr !== D1040) begin n_fail++; $display("FAIL ev_instr1040: got %h want %h", if_id_instr, D1040); end
    redirect_valid = 1'b1; redirect_pc = 32'h1000;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (instruction_not_ready !== 1'b1) begin n_fail++; $display("FAIL ev_evicted: got %b want 1", instruction_not_ready); end
    tick();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ev_refill_req: got %b want 1", imem_req); end
    // Reset in the middle of the refill.
    reset_n = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rf_req_drop: got %b want 0", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    // Late ack arrives in IDLE after reset; redirect to 0 (miss_addr's line)
    // keeps the FSM in IDLE so any stray write would turn PC 0 into a hit.
    reset_n = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rf_req_idle: got %b want 0", imem_req); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rf_valid: got %b want 0", if_id_valid); end
    tick();
    imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
    n_checks++; if (instruction_not_ready !== 1'b1) begin n_fail++; $display("FAIL rf_no_write: got %b want 1", instruction_not_ready); end
    tick();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rf_pc0_req: got %b want 1", imem_req); end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_redirect_hit();
    test_fill_redirect();
    test_stall_bubble();
    test_evict_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage with PC register, small direct-mapped instruction cache, miss-fill FSM and IF/ID pipeline register. It is directly upstream of stall_control: it produces instruction_not_ready and consumes the fetch/decode stall and bubble decisions. Redirects come from execute (branch resolved not as predicted), iret, or an exception vector. Decode reads the if_id_* outputs.

Parameters:
PC_WIDTH, 32, program counter and memory address width
INSTR_WIDTH, 32, instruction word width
LINES, 16, cache entries (one word per line, power of 2)
BOOT_PC, 32'h0000_1000, PC value loaded at reset

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous active-low reset
stall_in  in  1  hold PC and IF/ID (driven by stall_control)
bubble_in  in  1  force IF/ID to bubble next edge (driven by stall_control)
redirect_valid  in  1  PC redirect request (branch, iret or exception)
redirect_pc  in  PC_WIDTH  redirect target
imem_ack  in  1  fill data valid, single-cycle pulse
imem_rdata  in  INSTR_WIDTH  fill data, sampled when imem_ack=1
imem_req  out  1  fill request, level, held until ack
imem_addr  out  PC_WIDTH  word-aligned fill address
instruction_not_ready  out  1  current PC has no instruction this cycle
if_id_valid  out  1  IF/ID holds a real instruction
if_id_pc  out  PC_WIDTH  PC of the IF/ID instruction
if_id_instr  out  INSTR_WIDTH  IF/ID instruction; 0 (NOP) when a bubble

Behaviour:
- Reset (async on reset_n low, held while low): pc=BOOT_PC, state=IDLE, all valid bits=0, miss_addr=0, if_id_valid=0, if_id_pc=0, if_id_instr=0. Resulting outputs: imem_req=0, imem_addr=0. instruction_not_ready reflects the combinational lookup of BOOT_PC (1 after reset because the cache is empty).
- Address split: index = pc[log2(LINES)+1:2]; tag = pc[PC_WIDTH-1:log2(LINES)+2]; pc[1:0] are always 0. redirect_pc[1:0] is forced to 0 when loaded.
- hit = valid[index] && tag_ram[index]==tag. Lookup is combinational and has no latency.
- instruction_not_ready = (state==FILL) || (state==IDLE && !hit).
- FSM states:
  - IDLE to FILL: on a miss with redirect_valid=0. miss_addr<=pc. The fill starts even when stall_in=1.
  - IDLE on a miss with redirect_valid=1: stays IDLE. No request is issued.
  - FILL: imem_req=1 and imem_addr=miss_addr for every FILL cycle.
  - FILL to IDLE: on imem_ack. Line at miss_addr's index is written (data, tag, valid=1), evicting any prior occupant.
  - FILL cannot be cancelled. A redirect during FILL updates pc only. The pending fill still completes and is written, because the data is correct for miss_addr.
  - imem_ack in IDLE is ignored.
- PC update priority:
  1. redirect_valid: pc<=redirect_pc.
  2. stall_in: hold.
  3. instruction_not_ready: hold.
  4. Otherwise pc<=pc+4, wrapping modulo 2^PC_WIDTH.
- IF/ID update priority:
  1. redirect_valid or bubble_in: valid=0, instr=0, pc=0.
  2. stall_in: hold all fields.
  3. instruction_not_ready: valid=0, instr=0, pc=0.
  4. Otherwise: valid=1, pc<=pc, instr<=cached data.
- Miss penalty: 1 lookup cycle, then FILL cycles up to and including the ack cycle, then 1 hit cycle, then the IF/ID load.
- Reset mid-FILL aborts the fill. imem_req drops immediately and a later ack is ignored.
- Simultaneous ack and redirect in FILL: the line is written, state goes to IDLE, and pc takes the redirect target.

Test Plan:
1. Release reset, no ack -> cycle 0: pc=0x1000, not_ready=1, imem_req=0, if_id_valid=0. Cycle 1 onward: imem_req=1, imem_addr=0x1000 held.
2. Ack 3 cycles after req with rdata=0x2002_0001 -> next cycle hit=1, not_ready=0. Following edge: if_id_valid=1, if_id_pc=0x1000, if_id_instr=0x2002_0001, pc=0x1004.
3. After filling 0x1000, redirect_pc=0x1000 -> one cycle later the hit delivers instr with no imem_req pulse. Redirect cycle leaves if_id_valid=0.
4. In FILL for 0x1004, redirect_valid=1 with redirect_pc=0x3002 -> pc=0x3000. Ack still writes line 1 with tag for 0x1004. Next cycle starts a new FILL with imem_addr=0x3000.
5. Hit stream with stall_in=1 for 2 cycles -> pc and if_id_* frozen. Then bubble_in=1 for 1 cycle -> if_id_valid=0 and if_id_instr=0, pc advances by 4.
6. Fill 0x1000, then fetch 0x1040 (same index 0) -> miss and eviction. Refetch 0x1000 -> misses again. Reset_n low during that fill, then ack -> imem_req=0 and no line written.
